sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Schedules access to the shared SDRAM command engine among three requesters: a periodic auto-refresh generator (internal), the write path (UART RX buffer) and the read path (key-triggered read).
- Sits between the FIFO/request logic of the SDRAM controller and the command/timing engine that drives the SDRAM pins.
- Issues one operation at a time. Refresh always has top priority. Write and read share the remaining bandwidth round-robin.

Parameters:
- ADDR_W, 24, burst start address width (bank 2 + row 13 + col 9).
- REF_PERIOD, 780, clk cycles between refresh requests (7.8 us at 100 MHz).
- REF_MAX, 3, maximum queued refresh requests (saturation value of ref_cnt).

Ports:
- clk  in  1  system clock (100 MHz controller domain)
- rst  in  1  synchronous reset, active-high
- init_done  in  1  SDRAM power-up/mode-register sequence complete; level
- wr_req  in  1  write burst request; level, held until wr_ack
- wr_addr  in  ADDR_W  write burst start address; stable while wr_req
- wr_ack  out  1  one-cycle pulse: write accepted by engine
- rd_req  in  1  read burst request; level, held until rd_ack
- rd_addr  in  ADDR_W  read burst start address; stable while rd_req
- rd_ack  out  1  one-cycle pulse: read accepted by engine
- cmd_vld  out  1  operation offered to engine
- cmd_type  out  2  01 write, 10 read, 11 auto-refresh, 00 none
- cmd_addr  out  ADDR_W  address for write/read; 0 for refresh
- cmd_rdy  in  1  engine accepts offered operation this cycle
- cmd_done  in  1  one-cycle pulse: engine finished current operation
- ref_cnt  out  2  number of pending refreshes
- ref_ovf  out  1  sticky: refresh request arrived while ref_cnt == REF_MAX
- busy  out  1  high in ISSUE or EXEC

Behaviour:
- Reset values: cmd_vld 0, cmd_type 00, cmd_addr 0, wr_ack 0, rd_ack 0, ref_cnt 0, ref_ovf 0, busy 0. State WAIT_INIT. Refresh timer 0. Round-robin pointer = write-first.
- Refresh timer:
  - Counts only while init_done = 1. Counts 0..REF_PERIOD-1 and wraps.
  - On wrap: ref_cnt += 1, saturating at REF_MAX. If a wrap occurs at saturation, set ref_ovf; it clears only on rst.
  - A refresh acceptance (cmd_vld & cmd_rdy & type 11) decrements ref_cnt.
  - Increment and decrement in the same cycle leave ref_cnt unchanged.
- FSM:
  - WAIT_INIT: no grants; wr_req/rd_req are ignored and remain pending. Go to IDLE when init_done = 1.
  - IDLE: decide in one cycle, then go to ISSUE. The decision registers cmd_type, cmd_addr and cmd_vld = 1 on the next edge. Priority:
    - ref_cnt > 0: refresh.
    - Else wr_req & rd_req: grant the side named by the pointer; the pointer then flips to the other side.
    - Else wr_req: write, pointer set to read.
    - Else rd_req: read, pointer set to write.
    - Else stay in IDLE.
  - ISSUE: hold cmd_vld, cmd_type and cmd_addr stable until cmd_rdy. In the cmd_rdy cycle:
    - Pulse wr_ack or rd_ack (registered, visible the following cycle, exactly one cycle wide). A refresh produces no ack.
    - Drop cmd_vld and clear cmd_type to 00.
    - Go to EXEC.
  - EXEC: wait for cmd_done, then go to IDLE. cmd_done in any other state is ignored.
- Latency: request seen in IDLE -> cmd_vld high 1 cycle later. Minimum gap between consecutive cmd_vld assertions is 3 cycles (EXEC with immediate cmd_done, then IDLE decision).
- A refresh that becomes pending during ISSUE/EXEC does not pre-empt the current operation. It wins at the next IDLE decision even when wr_req/rd_req are present. The round-robin pointer does not change on refresh grants.
- A requester dropping req before ack is a protocol violation. A decision already made still issues.
- init_done falling: the timer freezes. The current operation completes, then the FSM goes to WAIT_INIT. ref_cnt is retained.
- Reset mid-operation: all state returns to reset values immediately on the clock edge with rst = 1. No ack is emitted.

Test Plan:
1. Reset with init_done = 0, wr_req = 1 for 50 cycles -> no cmd_vld, no wr_ack. Raise init_done -> cmd_vld with cmd_type 01 two cycles later, cmd_addr = wr_addr.
2. wr_req and rd_req both held, cmd_rdy = 1, cmd_done 2 cycles after each accept, REF_PERIOD large -> cmd_type sequence 01,10,01,10; exactly one wr_ack/rd_ack pulse per grant.
3. REF_PERIOD = 20, no wr/rd requests, engine prompt -> refresh issued every 20 cycles; ref_cnt toggles 0->1->0; ref_ovf stays 0.
4. REF_PERIOD = 20, engine stalls cmd_done for 100 cycles -> ref_cnt saturates at 3, ref_ovf = 1. After release, three refreshes issue back-to-back before a pending rd_req is granted.
5. Refresh timer wrap in the same cycle as a refresh accept -> ref_cnt unchanged (1 stays 1).
6. Assert rst while in ISSUE with cmd_vld = 1 -> next cycle cmd_vld = 0, ref_cnt = 0, no ack pulse; state WAIT_INIT.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Request/command bus between the SDRAM request logic, the arbiter and the command engine.
// The arbiter connects through the master modport; requesters and the engine use the slave view.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              cmd_vld;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rdy;
  logic              cmd_done;

  modport master (
    input  wr_req, wr_addr, rd_req, rd_addr, cmd_rdy, cmd_done,
    output wr_ack, rd_ack, cmd_vld, cmd_type, cmd_addr
  );

  modport slave (
    output wr_req, wr_addr, rd_req, rd_addr, cmd_rdy, cmd_done,
    input  wr_ack, rd_ack, cmd_vld, cmd_type, cmd_addr
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Schedules refresh, write and read operations onto the single SDRAM command engine.
// Refresh has strict priority; write and read alternate round-robin when both are waiting.
module sdram_arbiter #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned REF_MAX    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init_done,
  sdram_arbiter_if.master bus,
  output logic [1:0]     ref_cnt,
  output logic           ref_ovf,
  output logic           busy
);

  localparam int unsigned TMR_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_REF  = 2'b11;

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, EXEC} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  ref_tmr, ref_tmr_nxt;
  logic [1:0]        ref_cnt_nxt;
  logic              ref_ovf_nxt;
  logic              rr_wr, rr_wr_nxt;
  logic              cmd_vld_nxt;
  logic [1:0]        cmd_type_nxt;
  logic [ADDR_W-1:0] cmd_addr_nxt;
  logic              wr_ack_nxt, rd_ack_nxt, busy_nxt;
  logic              ref_wrap, ref_take;

  // Refresh bookkeeping plus arbitration FSM next-state/outputs
  always_comb begin
    ref_wrap     = init_done && (ref_tmr == TMR_W'(REF_PERIOD - 1));
    ref_take     = bus.cmd_vld && bus.cmd_rdy && (bus.cmd_type == CMD_REF);
    ref_tmr_nxt  = ref_tmr;
    ref_cnt_nxt  = ref_cnt;
    ref_ovf_nxt  = ref_ovf;
    state_nxt    = state;
    rr_wr_nxt    = rr_wr;
    cmd_vld_nxt  = bus.cmd_vld;
    cmd_type_nxt = bus.cmd_type;
    cmd_addr_nxt = bus.cmd_addr;
    wr_ack_nxt   = 1'b0;
    rd_ack_nxt   = 1'b0;

    if (init_done) ref_tmr_nxt = ref_wrap ? '0 : ref_tmr + TMR_W'(1);

    // A wrap and an accepted refresh in the same cycle cancel out
    case ({ref_wrap, ref_take})
      2'b10:   if (ref_cnt != 2'(REF_MAX)) ref_cnt_nxt = ref_cnt + 2'd1;
      2'b01:   if (ref_cnt != 2'd0) ref_cnt_nxt = ref_cnt - 2'd1;
      default: ref_cnt_nxt = ref_cnt;
    endcase
    if (ref_wrap && (ref_cnt == 2'(REF_MAX))) ref_ovf_nxt = 1'b1;

    case (state)
      WAIT_INIT: if (init_done) state_nxt = IDLE;
      IDLE: begin
        if (!init_done) begin
          state_nxt = WAIT_INIT;
        end else if (ref_cnt != 2'd0) begin
          state_nxt    = ISSUE;
          cmd_vld_nxt  = 1'b1;
          cmd_type_nxt = CMD_REF;
          cmd_addr_nxt = '0;
        end else if (bus.wr_req && (rr_wr || !bus.rd_req)) begin
          state_nxt    = ISSUE;
          cmd_vld_nxt  = 1'b1;
          cmd_type_nxt = CMD_WR;
          cmd_addr_nxt = bus.wr_addr;
          rr_wr_nxt    = 1'b0;
        end else if (bus.rd_req) begin
          state_nxt    = ISSUE;
          cmd_vld_nxt  = 1'b1;
          cmd_type_nxt = CMD_RD;
          cmd_addr_nxt = bus.rd_addr;
          rr_wr_nxt    = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.cmd_rdy) begin
          state_nxt    = EXEC;
          cmd_vld_nxt  = 1'b0;
          cmd_type_nxt = CMD_NONE;
          wr_ack_nxt   = (bus.cmd_type == CMD_WR);
          rd_ack_nxt   = (bus.cmd_type == CMD_RD);
        end
      end
      EXEC:    if (bus.cmd_done) state_nxt = init_done ? IDLE : WAIT_INIT;
      default: state_nxt = WAIT_INIT;
    endcase

    busy_nxt = (state_nxt == ISSUE) || (state_nxt == EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_INIT;
      ref_tmr      <= '0;
      ref_cnt      <= 2'd0;
      ref_ovf      <= 1'b0;
      rr_wr        <= 1'b1;
      bus.cmd_vld  <= 1'b0;
      bus.cmd_type <= CMD_NONE;
      bus.cmd_addr <= '0;
      bus.wr_ack   <= 1'b0;
      bus.rd_ack   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ref_tmr      <= ref_tmr_nxt;
      ref_cnt      <= ref_cnt_nxt;
      ref_ovf      <= ref_ovf_nxt;
      rr_wr        <= rr_wr_nxt;
      bus.cmd_vld  <= cmd_vld_nxt;
      bus.cmd_type <= cmd_type_nxt;
      bus.cmd_addr <= cmd_addr_nxt;
      bus.wr_ack   <= wr_ack_nxt;
      bus.rd_ack   <= rd_ack_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: an engine/requester model on the falling edge,
// directed scenarios on the rising edge, expected grants queued in order of issue.
module tb_sdram_arbiter;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned REF_PERIOD = 20;
  localparam int unsigned REF_MAX    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic [1:0] ref_cnt;
  logic       ref_ovf;
  logic       busy;

  sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .REF_PERIOD(REF_PERIOD), .REF_MAX(REF_MAX)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .bus(bus),
    .ref_cnt(ref_cnt), .ref_ovf(ref_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+1:0] exp_q[$];
  logic [1:0]        type_log[$];
  int                ref_cyc[$];

  // Scenario controls, written only by the scenario process
  logic              rdy_en = 1'b1;
  logic              release_done = 1'b0;
  int                done_dly = 2;
  int                wr_left = 0;
  int                rd_left = 0;
  logic [ADDR_W-1:0] wr_base = '0;
  logic [ADDR_W-1:0] rd_base = '0;

  // Observations, written only by the engine process
  int         cyc = 0;
  int         done_in = 0;
  int         wr_done = 0;
  int         rd_done = 0;
  int         ref_acc = 0;
  int         vld_cnt = 0;
  int         wr_ack_cnt = 0;
  int         rd_ack_cnt = 0;
  logic [1:0] max_ref = '0;
  logic       pend_wr = 1'b0;
  logic       pend_rd = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W+1:0] ent(input logic [1:0] t, input logic [ADDR_W-1:0] a);
    return {t, a};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic init);
    rst = 1'b1;
    init_done = init;
    rdy_en = 1'b1;
    done_dly = 2;
    wr_left = 0;
    rd_left = 0;
    exp_q.delete();
    tick(3);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (exp_q.size() == 0 && !busy && !bus.cmd_vld) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  // Engine and requester model: accepts offers, returns cmd_done, scores grants and acks
  initial begin : engine
    logic [ADDR_W+1:0] e;
    bus.cmd_rdy  = 1'b0;
    bus.cmd_done = 1'b0;
    bus.wr_req   = 1'b0;
    bus.rd_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.rd_addr  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.cmd_done = 1'b0;
      if (rst) begin
        done_in = 0; wr_done = 0; rd_done = 0; ref_acc = 0; vld_cnt = 0;
        wr_ack_cnt = 0; rd_ack_cnt = 0; max_ref = '0;
        pend_wr = 1'b0; pend_rd = 1'b0; bus.cmd_rdy = 1'b0;
        type_log.delete();
        ref_cyc.delete();
      end else begin
        check_eq("wr_ack", 32'(bus.wr_ack), 32'(pend_wr));
        check_eq("rd_ack", 32'(bus.rd_ack), 32'(pend_rd));
        if (bus.wr_ack) begin wr_ack_cnt++; wr_done++; end
        if (bus.rd_ack) begin rd_ack_cnt++; rd_done++; end
        if (release_done || done_in == 1) bus.cmd_done = 1'b1;
        if (done_in > 0) done_in--;
        if (bus.cmd_vld) vld_cnt++;
        if (ref_cnt > max_ref) max_ref = ref_cnt;
        bus.cmd_rdy = rdy_en;
        pend_wr = 1'b0;
        pend_rd = 1'b0;
        if (bus.cmd_vld && bus.cmd_rdy) begin
          type_log.push_back(bus.cmd_type);
          if (done_dly > 0) done_in = done_dly;
          if (bus.cmd_type == 2'b11) begin
            ref_acc++;
            ref_cyc.push_back(cyc);
            check_eq("ref_addr", 32'(bus.cmd_addr), 32'd0);
          end else if (exp_q.size() == 0) begin
            check_eq("grant_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("grant", 32'({bus.cmd_type, bus.cmd_addr}), 32'(e));
            pend_wr = (bus.cmd_type == 2'b01);
            pend_rd = (bus.cmd_type == 2'b10);
          end
        end
      end
      bus.wr_req  = (wr_done < wr_left);
      bus.rd_req  = (rd_done < rd_left);
      bus.wr_addr = wr_base + ADDR_W'(wr_done);
      bus.rd_addr = rd_base + ADDR_W'(rd_done);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : scenario
    logic [1:0] exp_types[5];
    bit ok;
    int a0;

    // Requests ignored until init_done, then a write issues two cycles later
    do_reset(1'b0);
    check_eq("rst_cmd_vld", 32'(bus.cmd_vld), 32'd0);
    check_eq("rst_cmd_type", 32'(bus.cmd_type), 32'd0);
    check_eq("rst_ref_cnt", 32'(ref_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    wr_base = 24'h0A_1234;
    wr_left = 1;
    exp_q.push_back(ent(2'b01, 24'h0A_1234));
    tick(50);
    check_eq("t1_no_vld", 32'(vld_cnt), 32'd0);
    check_eq("t1_no_busy", 32'(busy), 32'd0);
    init_done = 1'b1;
    tick(1);
    check_eq("t1_vld_early", 32'(bus.cmd_vld), 32'd0);
    tick(1);
    check_eq("t1_vld", 32'(bus.cmd_vld), 32'd1);
    check_eq("t1_type", 32'(bus.cmd_type), 32'd1);
    check_eq("t1_addr", 32'(bus.cmd_addr), 32'h0A_1234);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_drain("t1_drain", 40);

    // Round-robin between held write and read requests
    do_reset(1'b1);
    wr_base = 24'h10_0000;
    rd_base = 24'h20_0000;
    exp_q.push_back(ent(2'b01, 24'h10_0000));
    exp_q.push_back(ent(2'b10, 24'h20_0000));
    exp_q.push_back(ent(2'b01, 24'h10_0001));
    exp_q.push_back(ent(2'b10, 24'h20_0001));
    wr_left = 2;
    rd_left = 2;
    wait_drain("t2_drain", 100);
    check_eq("t2_wr_acks", 32'(wr_ack_cnt), 32'd2);
    check_eq("t2_rd_acks", 32'(rd_ack_cnt), 32'd2);

    // Periodic refresh with a prompt engine
    do_reset(1'b1);
    tick(75);
    check_eq("t3_ref_count", 32'(ref_acc), 32'd3);
    for (int i = 1; i < ref_cyc.size(); i++)
      check_eq("t3_ref_period", 32'(ref_cyc[i] - ref_cyc[i-1]), 32'(REF_PERIOD));
    check_eq("t3_max_ref_cnt", 32'(max_ref), 32'd1);
    check_eq("t3_ref_ovf", 32'(ref_ovf), 32'd0);

    // Stalled engine: refresh saturates, overflows, then drains ahead of a read
    do_reset(1'b1);
    done_dly = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ref_acc == 1) begin ok = 1'b1; break; end
    end
    check_eq("t4_first_ref", 32'(ok), 32'd1);
    rd_base = 24'h3C_0042;
    exp_q.push_back(ent(2'b10, 24'h3C_0042));
    rd_left = 1;
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (ref_ovf) begin ok = 1'b1; break; end
    end
    check_eq("t4_ovf_seen", 32'(ok), 32'd1);
    check_eq("t4_ref_sat", 32'(ref_cnt), 32'd3);
    check_eq("t4_busy_stall", 32'(busy), 32'd1);
    done_dly = 2;
    release_done = 1'b1;
    tick(1);
    release_done = 1'b0;
    wait_drain("t4_drain", 100);
    exp_types = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    check_eq("t4_grant_count", 32'(type_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < type_log.size(); i++)
      check_eq("t4_grant_order", 32'(type_log[i]), 32'(exp_types[i]));
    check_eq("t4_ovf_sticky", 32'(ref_ovf), 32'd1);

    // Timer wrap coinciding with a refresh accept keeps ref_cnt at 1
    do_reset(1'b1);
    rdy_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ref_cnt == 2'd1) begin ok = 1'b1; break; end
    end
    check_eq("t5_first_wrap", 32'(ok), 32'd1);
    tick(REF_PERIOD - 1);
    a0 = ref_acc;
    rdy_en = 1'b1;
    tick(1);
    check_eq("t5_accepted", 32'(ref_acc), 32'(a0 + 1));
    check_eq("t5_ref_cnt_hold", 32'(ref_cnt), 32'd1);
    tick(15);
    check_eq("t5_ref_cnt_drain", 32'(ref_cnt), 32'd0);
    check_eq("t5_ref_acc", 32'(ref_acc), 32'(a0 + 2));
    check_eq("t5_ref_ovf", 32'(ref_ovf), 32'd0);

    // Reset while a write is offered, then the still-held request issues after init
    do_reset(1'b1);
    rdy_en = 1'b0;
    wr_base = 24'h05_5AA5;
    wr_left = 1;
    tick(3);
    check_eq("t6_vld", 32'(bus.cmd_vld), 32'd1);
    check_eq("t6_type", 32'(bus.cmd_type), 32'd1);
    tick(REF_PERIOD + 2);
    check_eq("t6_no_preempt_type", 32'(bus.cmd_type), 32'd1);
    check_eq("t6_no_preempt_addr", 32'(bus.cmd_addr), 32'h05_5AA5);
    check_eq("t6_ref_pending", 32'(ref_cnt), 32'd1);
    rst = 1'b1;
    init_done = 1'b0;
    tick(1);
    check_eq("t6_rst_vld", 32'(bus.cmd_vld), 32'd0);
    check_eq("t6_rst_type", 32'(bus.cmd_type), 32'd0);
    check_eq("t6_rst_addr", 32'(bus.cmd_addr), 32'd0);
    check_eq("t6_rst_ref_cnt", 32'(ref_cnt), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    rdy_en = 1'b1;
    tick(10);
    check_eq("t6_wait_init_vld", 32'(bus.cmd_vld), 32'd0);
    check_eq("t6_wait_init_busy", 32'(busy), 32'd0);
    exp_q.push_back(ent(2'b01, 24'h05_5AA5));
    init_done = 1'b1;
    wait_drain("t6_drain", 40);
    check_eq("t6_wr_acks", 32'(wr_ack_cnt), 32'd1);

    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
